// File: rtl/dac_frame_tx.sv
// dac_frame_tx: DAC output stage fed by the harmonic accumulators.
// On a start pulse it latches the signed 32-bit left/right totals. Each total
// is scaled by an arithmetic right shift, saturated to the DAC word width and
// converted to offset binary. The stage then sends two command-prefixed frames
// (left, then right) to the DAC over SPI mode 0, and pulses o_Done at the end.
//
// Ports:
//   Main_Clock              system clock
//   Reset                   synchronous, active-high
//   i_Start                 one-cycle transfer request
//   i_Sample_L/i_Sample_R   signed 32-bit accumulator totals
//   o_SPI_CS/o_SPI_Clock/o_SPI_Data   SPI mode 0 (CS active low, clock idles low, MSB first)
//   o_Busy                  transfer in progress
//   o_Done                  one-cycle pulse after the right frame and its CS gap
//   o_Clip_L/o_Clip_R       saturation flags from the most recent latch
//   o_Overrun               sticky: a start arrived while busy
// All outputs are registered.
module dac_frame_tx #(
    parameter int unsigned         SHIFT    = 8,
    parameter int unsigned         DAC_BITS = 16,
    parameter int unsigned         CMD_BITS = 8,
    parameter logic [CMD_BITS-1:0] CMD_L    = 8'h31,
    parameter logic [CMD_BITS-1:0] CMD_R    = 8'h32,
    parameter int unsigned         CLK_DIV  = 4,
    parameter int unsigned         CS_GAP   = 2
) (
    input  logic        Main_Clock,
    input  logic        Reset,
    input  logic        i_Start,
    input  logic [31:0] i_Sample_L,
    input  logic [31:0] i_Sample_R,
    output logic        o_SPI_CS,
    output logic        o_SPI_Clock,
    output logic        o_SPI_Data,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Clip_L,
    output logic        o_Clip_R,
    output logic        o_Overrun
);

    localparam int unsigned FRAME_BITS = CMD_BITS + DAC_BITS;
    localparam int unsigned FRAME_MSB  = FRAME_BITS - 1;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned CNT_MAX    = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic signed [31:0] SAT_MAX  = (32'sh1 <<< (DAC_BITS - 1)) - 32'sh1;
    localparam logic signed [31:0] SAT_MIN  = -(32'sh1 <<< (DAC_BITS - 1));
    localparam logic [DAC_BITS-1:0] MSB_MASK = {1'b1, {(DAC_BITS - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0]           samp_l;
    logic [31:0]           samp_r;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] frame_r;
    logic [BIT_W-1:0]      bit_idx;
    logic [CNT_W-1:0]      cnt;
    logic                  chan_r;

    logic [DAC_BITS:0]     conv_l;
    logic [DAC_BITS:0]     conv_r;
    logic [FRAME_BITS-1:0] frame_l_c;
    logic [FRAME_BITS-1:0] frame_r_c;

    logic cs_c;
    logic sclk_c;
    logic data_c;
    logic busy_c;
    logic done_c;
    logic overrun_c;
    logic busy_state;
    logic accept;

    // Shift, saturate, convert to offset binary; returns {clip, word}.
    function automatic logic [DAC_BITS:0] to_dac(input logic [31:0] raw);
        logic signed [31:0] s;
        logic signed [31:0] c;
        logic               clip;
        s = $signed(raw) >>> SHIFT;
        if (s > SAT_MAX) begin
            c    = SAT_MAX;
            clip = 1'b1;
        end else if (s < SAT_MIN) begin
            c    = SAT_MIN;
            clip = 1'b1;
        end else begin
            c    = s;
            clip = 1'b0;
        end
        return {clip, DAC_BITS'(c) ^ MSB_MASK};
    endfunction

    // Frame assembly from the latched totals.
    always_comb begin
        conv_l    = to_dac(samp_l);
        conv_r    = to_dac(samp_r);
        frame_l_c = {CMD_L, conv_l[DAC_BITS-1:0]};
        frame_r_c = {CMD_R, conv_r[DAC_BITS-1:0]};
    end

    assign busy_state = (state == LATCH) || (state == SHIFT_LO) ||
                        (state == SHIFT_HI) || (state == GAP);
    assign accept     = i_Start && ((state == IDLE) || (state == DONE));

    // State register.
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (i_Start) next_state = LATCH;
            LATCH:    next_state = SHIFT_LO;
            SHIFT_LO: if (cnt == CNT_W'(CLK_DIV - 1)) next_state = SHIFT_HI;
            SHIFT_HI: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    next_state = (bit_idx == '0) ? GAP : SHIFT_LO;
                end
            end
            GAP:      if (cnt == CNT_W'(CS_GAP - 1)) next_state = chan_r ? DONE : SHIFT_LO;
            DONE:     next_state = i_Start ? LATCH : IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the
    // upcoming state so each output lines up with the state it belongs to.
    always_comb begin
        cs_c      = 1'b1;
        sclk_c    = 1'b0;
        data_c    = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        overrun_c = o_Overrun | (i_Start & busy_state);
        case (next_state)
            LATCH: busy_c = 1'b1;
            SHIFT_LO: begin
                cs_c   = 1'b0;
                busy_c = 1'b1;
                // Data only changes on entry to SHIFT_LO.
                case (state)
                    SHIFT_LO: data_c = o_SPI_Data;
                    SHIFT_HI: data_c = shreg[FRAME_MSB-1];
                    GAP:      data_c = frame_r[FRAME_MSB];
                    default:  data_c = frame_l_c[FRAME_MSB];
                endcase
            end
            SHIFT_HI: begin
                cs_c   = 1'b0;
                sclk_c = 1'b1;
                busy_c = 1'b1;
                data_c = o_SPI_Data;
            end
            GAP:     busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            o_SPI_CS    <= 1'b1;
            o_SPI_Clock <= 1'b0;
            o_SPI_Data  <= 1'b0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_Overrun   <= 1'b0;
        end else begin
            o_SPI_CS    <= cs_c;
            o_SPI_Clock <= sclk_c;
            o_SPI_Data  <= data_c;
            o_Busy      <= busy_c;
            o_Done      <= done_c;
            o_Overrun   <= overrun_c;
        end
    end

    // Datapath: sample capture, frame shift register, bit and phase counters.
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            samp_l   <= '0;
            samp_r   <= '0;
            shreg    <= '0;
            frame_r  <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            chan_r   <= 1'b0;
            o_Clip_L <= 1'b0;
            o_Clip_R <= 1'b0;
        end else begin
            if (accept) begin
                samp_l <= i_Sample_L;
                samp_r <= i_Sample_R;
            end

            if (state == LATCH) begin
                shreg    <= frame_l_c;
                frame_r  <= frame_r_c;
                bit_idx  <= BIT_W'(FRAME_MSB);
                chan_r   <= 1'b0;
                o_Clip_L <= conv_l[DAC_BITS];
                o_Clip_R <= conv_r[DAC_BITS];
            end else if (state == SHIFT_HI && next_state == SHIFT_LO) begin
                shreg   <= shreg << 1;
                bit_idx <= bit_idx - BIT_W'(1);
            end else if (state == GAP && next_state == SHIFT_LO) begin
                shreg   <= frame_r;
                bit_idx <= BIT_W'(FRAME_MSB);
                chan_r  <= 1'b1;
            end

            // Phase counter restarts on every state change.
            if (next_state != state) begin
                cnt <= '0;
            end else if (busy_state) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
